// File: rtl/sha2_pkg.sv
// sha2_pkg: shared state encoding, pad byte and SHA-2 block configurations
package sha2_pkg;
  typedef enum logic [2:0] {FILL, PAD, ZERO, LEN, OUT} state_t;
  localparam logic [7:0] SHA2_PAD_BYTE = 8'h80;
  localparam int SHA256_PKT_CNT = 8;
  localparam int SHA256_LEN_W = 64;
  localparam int SHA512_PKT_CNT = 16;
  localparam int SHA512_LEN_W = 128;
endpackage

// File: rtl/sha2_last_fmt.sv
// sha2_last_fmt: keeps the valid bytes of a final packet, appends 0x80, zeroes the rest
module sha2_last_fmt import sha2_pkg::*; #(
  parameter int PKT_W = 64,
  localparam int BW = PKT_W / 8,
  localparam int CW = $clog2(BW) + 1
) (
  input  logic [PKT_W-1:0] pkt,
  input  logic [CW-1:0]    pkt_bytes,
  output logic [PKT_W-1:0] word
);
  always_comb begin
    word = '0;
    for (int i = 0; i < BW; i++)
      word[PKT_W-1-8*i -: 8] = CW'(i) < pkt_bytes ? pkt[PKT_W-1-8*i -: 8] :
                               CW'(i) == pkt_bytes ? SHA2_PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/sha2_blk_builder.sv
// sha2_blk_builder: packs a packet stream into SHA-2 blocks with automatic padding and length
module sha2_blk_builder import sha2_pkg::*; #(
  parameter int PKT_W = 64,
  parameter int PKT_CNT = SHA256_PKT_CNT,
  parameter int LEN_W = SHA256_LEN_W,
  localparam int LW = LEN_W / PKT_W,
  localparam int BW = PKT_W / 8,
  localparam int IW = $clog2(PKT_CNT),
  localparam int CW = $clog2(BW) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [PKT_W-1:0]         pkt,
  input  logic                     pkt_vld,
  input  logic                     pkt_last,
  input  logic [CW-1:0]            pkt_bytes,
  output logic                     pkt_rdy,
  output logic [PKT_W*PKT_CNT-1:0] blk,
  output logic                     blk_vld,
  output logic                     blk_last,
  input  logic                     blk_rdy,
  output logic [IW-1:0]            idx
);
  localparam logic [IW-1:0] LAST_I = IW'(PKT_CNT - 1);
  localparam logic [IW-1:0] LEN_I = IW'(PKT_CNT - LW);
  state_t state, nxt, ret, ret_n, pn;
  logic [PKT_W-1:0] mem [PKT_CNT];
  logic [PKT_W-1:0] fmt, wd;
  logic [LEN_W-1:0] len;
  logic last_r, we, acc, full;
  sha2_last_fmt #(.PKT_W(PKT_W)) u_fmt (.pkt(pkt), .pkt_bytes(pkt_bytes), .word(fmt));
  assign pkt_rdy = state == FILL;
  assign blk_vld = state == OUT;
  assign blk_last = blk_vld & last_r;
  assign acc = pkt_vld & pkt_rdy;
  assign full = idx == LAST_I;
  // after padding: block end forces OUT, otherwise zero-fill (spill included) up to the length slots
  assign pn = full ? OUT : (idx + 1'b1 == LEN_I ? LEN : ZERO);
  for (genvar g = 0; g < PKT_CNT; g++) assign blk[PKT_W*g +: PKT_W] = mem[g];
  always_comb begin
    nxt = state;
    ret_n = ret;
    we = 1'b0;
    wd = '0;
    case (state)
      FILL: if (acc) begin
        we = 1'b1;
        wd = pkt_last ? fmt : pkt;
        ret_n = !pkt_last ? FILL : pkt_bytes == CW'(BW) ? PAD : ZERO;
        nxt = full ? OUT : ret_n == ZERO ? pn : ret_n;
      end
      PAD: begin
        we = 1'b1;
        wd = {SHA2_PAD_BYTE, {(PKT_W-8){1'b0}}};
        ret_n = ZERO;
        nxt = pn;
      end
      ZERO: begin
        we = 1'b1;
        ret_n = ZERO;
        nxt = pn;
      end
      LEN: begin
        we = 1'b1;
        wd = PKT_W'(len >> (PKT_W * (LAST_I - idx)));
        nxt = full ? OUT : LEN;
      end
      OUT: nxt = blk_rdy ? (last_r ? FILL : ret) : OUT;
      default: nxt = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      ret <= FILL;
      idx <= '0;
      len <= '0;
      last_r <= 1'b0;
      for (int i = 0; i < PKT_CNT; i++) mem[i] <= '0;
    end else if (clr) begin
      state <= FILL;
      ret <= FILL;
      idx <= '0;
      len <= '0;
      last_r <= 1'b0;
      for (int i = 0; i < PKT_CNT; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      ret <= ret_n;
      if (we) begin
        mem[idx] <= wd;
        idx <= full ? idx : idx + 1'b1;
      end
      if (acc) len <= len + (pkt_last ? LEN_W'({pkt_bytes, 3'b000}) : LEN_W'(PKT_W));
      if (state == LEN && full) last_r <= 1'b1;
      if (state == OUT && blk_rdy) begin
        idx <= '0;
        if (last_r) begin
          len <= '0;
          last_r <= 1'b0;
        end
      end
    end
  end
endmodule
